// File: rtl/msk_sbox_sched_pkg.sv
// Shared definitions for the masked S-box column scheduler.
// FSM encodings, byte count, tag width and tag pipeline entry.
package msk_sbox_sched_pkg;

  localparam int NBYTES = 4;
  localparam int TAG_W  = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
  } tag_ent_t;

endpackage

// File: rtl/msk_sbox_tag_pipe.sv
// Fixed-depth shift pipe carrying {valid, tag} alongside the S-box.
// Depth matches S-box latency so tag pops with its result.
module msk_sbox_tag_pipe
  import msk_sbox_sched_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  tag_ent_t push,
  output tag_ent_t pop
);

  tag_ent_t stg [LAT];

  // Shift one stage per cycle; reset drops every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stg[i] <= '0;
    end else begin
      stg[0] <= push;
      for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
  end

  assign pop = stg[LAT-1];

endmodule

// File: rtl/msk_sbox_sched.sv
// Schedules the four bytes of a masked column through one shared
// masked S-box; shares are only routed and registered, never combined.
module msk_sbox_sched
  import msk_sbox_sched_pkg::*;
#(
  parameter int d   = 2,
  parameter int LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*d-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*d-1:0] out_data,
  output logic [8*d-1:0]  sb_in,
  output logic            sb_in_valid,
  input  logic [8*d-1:0]  sb_out,
  input  logic            rnd_valid,
  output logic            rnd_ready
);

  localparam int BW = 8*d;

  logic [1:0]                  state;
  logic [TAG_W-1:0]            cnt;
  logic [TAG_W-1:0]            coll;
  logic [NBYTES-1:0][BW-1:0]   col;
  logic [NBYTES-1:0][BW-1:0]   res;
  tag_ent_t                    push;
  tag_ent_t                    pop;
  logic                        issue;
  logic                        take;

  assign issue = (state == S_ISSUE) && rnd_valid;
  assign take  = pop.v &&
                 ((state == S_ISSUE) || (state == S_DRAIN));

  assign in_ready    = (state == S_IDLE) && !rst;
  assign out_valid   = (state == S_DONE);
  assign out_data    = res;
  assign sb_in_valid = issue;
  assign rnd_ready   = issue;
  assign sb_in       = issue ? col[cnt] : '0;

  assign push.v   = issue;
  assign push.tag = cnt;

  msk_sbox_tag_pipe #(
    .LAT (LAT)
  ) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop)
  );

  // Column FSM and issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      col   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            col   <= in_data;
            cnt   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (rnd_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == 2'd3) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (take && coll == 2'd3) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Collect S-box results into the slot named by the popped tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll <= '0;
      res  <= '0;
    end else if (take) begin
      res[pop.tag] <= sb_out;
      coll         <= coll + 1'b1;
    end
  end

endmodule

// File: tb/tb_msk_sbox_sched.sv
// Self-checking bench for msk_sbox_sched with a masked AES S-box model.
// Two instances: LAT=4 (main tests) and LAT=1 (back-to-back columns).
module tb_msk_sbox_sched;

  localparam int D    = 2;
  localparam int LAT1 = 4;
  localparam int LAT2 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT1 (LAT=4) ----------------
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [32*D-1:0] in_data, out_data;
  logic [8*D-1:0]  sb_in, sb_out;
  logic            sb_in_valid, rnd_valid, rnd_ready;

  msk_sbox_sched #(.d(D), .LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sb_in(sb_in), .sb_in_valid(sb_in_valid), .sb_out(sb_out),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready)
  );

  // ---------------- DUT2 (LAT=1) ----------------
  logic            in_valid2, in_ready2, out_valid2;
  logic            out_ready2 = 1'b1;
  logic            rnd_valid2 = 1'b1;
  logic [32*D-1:0] in_data2, out_data2;
  logic [8*D-1:0]  sb_in2, sb_out2;
  logic            sb_in_valid2, rnd_ready2;

  msk_sbox_sched #(.d(D), .LAT(LAT2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .sb_in(sb_in2), .sb_in_valid(sb_in_valid2), .sb_out(sb_out2),
    .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_i, input logic [7:0] b_i);
    logic [7:0] a, b, p;
    logic hi;
    a = a_i; b = b_i; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00)
      for (int i = 1; i < 256; i++)
        if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
               ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [8*D-1:0] mask_byte(input logic [7:0] v);
    logic [8*D-1:0] r;
    logic a, s;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      a = 1'b0;
      for (int j = 0; j < D-1; j++) begin
        s = 1'($urandom);
        r[b*D+j] = s;
        a = a ^ s;
      end
      r[b*D+D-1] = v[b] ^ a;
    end
    return r;
  endfunction

  function automatic logic [7:0] unmask_byte(input logic [8*D-1:0] x);
    logic [7:0] r;
    logic a;
    for (int b = 0; b < 8; b++) begin
      a = 1'b0;
      for (int j = 0; j < D; j++) a = a ^ x[b*D+j];
      r[b] = a;
    end
    return r;
  endfunction

  function automatic logic [32*D-1:0] mask_col(input logic [31:0] pt);
    logic [32*D-1:0] r;
    for (int i = 0; i < 4; i++) r[i*8*D +: 8*D] = mask_byte(pt[i*8 +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] unmask_col(input logic [32*D-1:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = unmask_byte(x[i*8*D +: 8*D]);
    return r;
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] pt);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = sbox(pt[i*8 +: 8]);
    return r;
  endfunction

  // ---------------- masked S-box models (fixed latency, fresh masks) ----------------
  logic [8*D-1:0] q1 [LAT1];
  logic [8*D-1:0] q2 [LAT2];

  always @(posedge clk) begin
    for (int i = LAT1-1; i > 0; i--) q1[i] <= q1[i-1];
    q1[0] <= sb_in_valid ? mask_byte(sbox(unmask_byte(sb_in)))
                         : (8*D)'($urandom);
  end
  assign sb_out = q1[LAT1-1];

  always @(posedge clk) begin
    q2[0] <= sb_in_valid2 ? mask_byte(sbox(unmask_byte(sb_in2)))
                          : (8*D)'($urandom);
  end
  assign sb_out2 = q2[LAT2-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One full column on DUT1: stall[k]=1 drops rnd_valid in cycle k after handshake.
  task automatic do_col(input logic [31:0] pt, input logic [39:0] stall,
                        input int bp, input logic [31:0] expv, input string nm);
    int exp_iss[4];
    int ne, n_iss, ov, w;
    logic [32*D-1:0] od;
    ne = 0;
    for (int k = 1; k < 40 && ne < 4; k++)
      if (!stall[k]) begin exp_iss[ne] = k; ne++; end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = mask_col(pt);
    out_ready = 1'b0;
    rnd_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = (32*D)'({$urandom, $urandom});
    n_iss = 0;
    ov = 0;
    for (int k = 1; k < 40; k++) begin
      rnd_valid = !stall[k];
      @(negedge clk);
      chk({nm, " rnd_ready"}, 64'(rnd_ready), 64'(sb_in_valid));
      if (sb_in_valid) begin
        if (n_iss < 4) begin
          chk({nm, " issue_cycle"}, 64'(k), 64'(exp_iss[n_iss]));
          chk({nm, " issue_byte"}, 64'(unmask_byte(sb_in)),
              64'(pt[n_iss*8 +: 8]));
        end
        n_iss++;
      end else begin
        chk({nm, " sb_in_zero"}, 64'(sb_in), 64'd0);
      end
      if (out_valid) begin ov = k; break; end
      @(posedge clk); #1;
    end
    rnd_valid = 1'b1;
    chk({nm, " n_issues"}, 64'(n_iss), 64'd4);
    chk({nm, " out_latency"}, 64'(ov), 64'(exp_iss[3] + 1 + LAT1));
    od = out_data;
    for (int j = 0; j < bp; j++) begin
      chk({nm, " bp_valid"}, 64'(out_valid), 64'd1);
      chk({nm, " bp_stable"}, 64'(out_data), 64'(od));
      chk({nm, " bp_in_ready"}, 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    chk({nm, " out_data"}, 64'(unmask_col(out_data)), 64'(expv));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({nm, " in_ready_after"}, 64'(in_ready), 64'd1);
    chk({nm, " out_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic [31:0] pt;
    logic [39:0] stall;
    int          bp;
    logic [31:0] expv;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pt, pt2;
    logic [31:0] qexp [$];
    int nh, no, last, w;
    logic hs;

    tbl[0] = '{32'h00000000, 40'h0,  0, 32'h63636363};
    tbl[1] = '{32'h53005300, 40'h0,  0, 32'hED63ED63};
    tbl[2] = '{32'hFF100153, 40'hC,  0, 32'h16CA7CED};
    tbl[3] = '{32'h01FF0010, 40'h0,  5, 32'h7C1663CA};
    tbl[4] = '{32'h53535353, 40'h1E, 2, 32'hEDEDEDED};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rnd_valid = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst sb_in_valid", 64'(sb_in_valid), 64'd0);
    chk("rst rnd_ready", 64'(rnd_ready), 64'd0);
    chk("rst sb_in", 64'(sb_in), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst in_ready", 64'(in_ready), 64'd1);

    foreach (tbl[i])
      do_col(tbl[i].pt, tbl[i].stall, tbl[i].bp, tbl[i].expv,
             $sformatf("vec%0d", i));

    // Reset at the second issue: outputs clear at once, old results vanish.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = mask_col(32'hA5A5A5A5);
    rnd_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    nh = 0;
    w = 0;
    while (nh < 2 && w < 10) begin
      @(negedge clk);
      if (sb_in_valid) nh++;
      w++;
    end
    chk("rstmid reached_issue2", 64'(nh), 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("rstmid sb_in_valid", 64'(sb_in_valid), 64'd0);
    chk("rstmid sb_in", 64'(sb_in), 64'd0);
    chk("rstmid rnd_ready", 64'(rnd_ready), 64'd0);
    chk("rstmid in_ready", 64'(in_ready), 64'd0);
    chk("rstmid out_valid", 64'(out_valid), 64'd0);
    chk("rstmid out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid in_ready_first", 64'(in_ready), 64'd1);
    do_col(32'h00015300, 40'h0, 1, model_col(32'h00015300), "after_rst");

    // Randomized columns against the reference model.
    for (int r = 0; r < 20; r++) begin
      pt = $urandom;
      do_col(pt, 40'($urandom & $urandom & $urandom) & 40'hFFFF,
             int'($urandom_range(0, 3)), model_col(pt),
             $sformatf("rand%0d", r));
    end

    // LAT=1 back-to-back columns, out_ready tied high.
    pt2 = $urandom;
    @(posedge clk); #1;
    in_data2  = mask_col(pt2);
    in_valid2 = 1'b1;
    nh = 0; no = 0; last = -1;
    for (int c = 0; c < 100 && (nh < 5 || no < 5); c++) begin
      @(negedge clk);
      hs = in_valid2 && in_ready2;
      if (hs) begin
        if (last >= 0) chk("lat1 hs_spacing", 64'(c - last), 64'd7);
        last = c;
        qexp.push_back(model_col(pt2));
        nh++;
      end
      if (out_valid2) begin
        if (qexp.size() > 0)
          chk("lat1 out_data", 64'(unmask_col(out_data2)), 64'(qexp.pop_front()));
        else
          chk("lat1 spurious_out", 64'd1, 64'd0);
        no++;
      end
      @(posedge clk); #1;
      if (hs) begin
        if (nh < 5) begin
          pt2 = $urandom;
          in_data2 = mask_col(pt2);
        end else begin
          in_valid2 = 1'b0;
        end
      end
    end
    chk("lat1 n_in", 64'(nh), 64'd5);
    chk("lat1 n_out", 64'(no), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msk_sbox_sched.md
MSK_SBOX_SCHED -- requirements
Module: msk_sbox_sched

Interface
REQ-001 The block SHALL have parameter d, default 2, meaning the number of shares per bit.
REQ-002 The block SHALL have parameter LAT, default 4, meaning the fixed latency in cycles of the shared masked S-box, with LAT >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a masked column is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the column this cycle.
REQ-007 The block SHALL have port in_data, input, 32*d bits: shares of bit b of byte i sit at [(8*i+b)*d +: d].
REQ-008 The block SHALL have port out_valid, output, 1 bit: a substituted column is available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the column.
REQ-010 The block SHALL have port out_data, output, 32*d bits: the substituted column, in the same layout as in_data.
REQ-011 The block SHALL have port sb_in, output, 8*d bits: the byte driven to the shared masked S-box.
REQ-012 The block SHALL have port sb_in_valid, output, 1 bit: sb_in carries a live byte this cycle.
REQ-013 The block SHALL have port sb_out, input, 8*d bits: S-box result, valid LAT cycles after the matching issue.
REQ-014 The block SHALL have port rnd_valid, input, 1 bit: PRNG randomness is available for an S-box evaluation.
REQ-015 The block SHALL have port rnd_ready, output, 1 bit: the randomness is consumed this cycle.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, ISSUE, DRAIN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 On an in_valid&&in_ready cycle, the block SHALL register in_data, clear the byte counter to 0, and enter ISSUE.
REQ-019 In ISSUE with rnd_valid=1, the block SHALL set sb_in=byte[cnt], sb_in_valid=1, rnd_ready=1, and increment cnt.
REQ-020 In ISSUE, the block SHALL move to DRAIN after issuing byte 3.
REQ-021 In ISSUE with rnd_valid=0, the block SHALL hold cnt, keep sb_in_valid=0 and rnd_ready=0, and drive sb_in all-zero; sb_in SHALL be all-zero whenever sb_in_valid=0, so that no stale shares are driven.
REQ-022 Every issue SHALL push {valid=1, tag=cnt} into a LAT-deep tag pipeline; non-issue cycles SHALL push valid=0.
REQ-023 When the pipeline output valid=1, sb_out SHALL be written into result slot tag on that edge.
REQ-024 The block SHALL keep a 2-bit collected-count and go from DRAIN to DONE on the edge that stores the 4th result; the collected-count SHALL wrap to 0 on that edge.
REQ-025 Results SHALL be accepted in ISSUE as well as DRAIN, because of overlap when LAT < 4 or when rnd stalls occur.
REQ-026 In DONE, out_valid SHALL be 1 and out_data SHALL be stable until out_ready=1; the block SHALL then enter IDLE.
REQ-027 in_ready SHALL assert in the cycle after the out handshake; there SHALL be no column overlap.
REQ-028 out_data SHALL be driven from the result register and SHALL NOT depend combinationally on sb_out.
REQ-029 With rnd_valid held at 1 and an input handshake at cycle t, issues SHALL occur at cycles t+1..t+4 and out_valid SHALL first be 1 at cycle t+5+LAT.
REQ-030 Each rnd stall cycle SHALL delay out_valid by exactly one cycle.
REQ-031 The block SHALL perform no arithmetic on shares: shares SHALL be routed and registered only, and SHALL never be XORed together.

Reset
REQ-032 On rst=1, the block SHALL enter IDLE and SHALL clear cnt, the collected-count and every tag pipeline valid bit immediately, without waiting for a clock edge.
REQ-033 During reset: in_ready=0, out_valid=0, sb_in_valid=0, rnd_ready=0, sb_in=0, out_data=0.
REQ-034 After rst falls, in_ready SHALL be 1 in the first cycle.
REQ-035 On reset mid-operation, in-flight S-box results SHALL be discarded and SHALL never appear on out_data.

Structure
REQ-036 A shared package SHALL hold the FSM state enumeration, NBYTES=4, and the tag width of 2.
REQ-037 The tag pipeline SHALL be a sub-module msk_sbox_tag_pipe (parameter LAT, 3-bit entry, async reset clears all entries).

Verification
REQ-038 Basic scenario: LAT=4, d=2, rnd_valid=1, one column handshake at cycle 10 -> sb_in_valid at cycles 11-14 with tags 0-3, out_valid at cycle 19, recombined output = AES S-box of each recombined input byte (00->63, 53->ED).
REQ-039 Randomness-stall scenario: rnd_valid low at cycles 12-13 -> issues at cycles 11, 14, 15, 16, out_valid at cycle 21, rnd_ready=0 during the stall, sb_in=0 at cycles 12-13.
REQ-040 Consumer back-pressure scenario: out_ready=0 for 5 cycles in DONE -> out_data stable throughout, in_ready=0; out_ready=1 -> in_ready=1 the next cycle.
REQ-041 Reset mid-operation scenario: rst pulses at the 2nd issue -> all outputs go 0 asynchronously; the next column yields only its own results.
REQ-042 LAT=1 scenario with back-to-back columns and out_ready tied to 1 -> each column takes 7 cycles from handshake to handshake, with no byte-slot mix-up.
